mp_add_seq: RTL
===============

# mp_add_seq

Multi-precision add sequencer that time-shares one existing 16-bit carry-lookahead adder (`CLA_16`) to add operands of `16*WORDS` bits. It processes one 16-bit word per clock, least-significant word first, and chains each word's carry-out into the next word's carry-in. It sits between a requesting datapath, which uses a start/ready handshake, and the shared `CLA_16`. Results are held until the requester acknowledges them.

## Interface
- `WORDS`, default 4: number of 16-bit words per operand; legal range 1..16.
- `CLK_in`, input, 1: clock; all state updates on the rising edge.
- `RST_in`, input, 1: reset, asynchronous, active-high.
- `Start_in`, input, 1: request; sampled only while `Ready_out`=1.
- `Ready_out`, output, 1: block idle, can accept a request.
- `A_in`, input, 16*WORDS: operand A; captured at accept.
- `B_in`, input, 16*WORDS: operand B; captured at accept.
- `C_in`, input, 1: initial carry-in; captured at accept.
- `Valid_out`, output, 1: `S_out`/`C_out` hold a complete result.
- `Ack_in`, input, 1: requester consumed the result; sampled only while `Valid_out`=1.
- `S_out`, output, 16*WORDS: sum, registered.
- `C_out`, output, 1: carry-out of the most-significant word, registered.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `Start_in`=1. On that edge, latch A, B and carry := `C_in`, set word index k := 0, and clear `S_out`.
- RUN, each cycle:
  - Drive `CLA_16` with A word k, B word k and the carry register.
  - On the edge, write the sum into `S_out` word k, carry := `CLA_16` carry-out, k := k+1.
- RUN → DONE on the edge that writes word WORDS-1. `C_out` := final carry on the same edge.
- DONE → IDLE when `Ack_in`=1. `S_out`/`C_out` keep their values until the next accept.
- `Start_in` outside IDLE is ignored. `Ack_in` outside DONE is ignored.
- `Ready_out` = (state==IDLE). `Valid_out` = (state==DONE). Both decode directly from the state register.
- Arithmetic: unsigned modulo 2^(16*WORDS). The overflow is reported only via `C_out`.
- Index counter width: clog2(WORDS) bits, minimum 1. k never exceeds WORDS-1.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset values: state IDLE, `Ready_out`=1, `Valid_out`=0, `S_out`=0, `C_out`=0, k=0, carry=0.
- Reset asserted in any state, including mid-RUN: immediate return to IDLE. In-flight operands and partial sum are discarded and outputs take their reset values.
- Latency: `Valid_out` rises exactly WORDS cycles after the accept edge.
- `Ready_out` returns 1 the cycle after the edge on which `Ack_in` is sampled.
- Minimum request-to-request spacing is WORDS+2 cycles.
- `Start_in` and `Ack_in` both high while in DONE: only the ack acts. The start is not accepted.
- Input operands may change freely after the accept edge.

## Configuration
- Macro: `MPADD_SUB_EN`.
- Defined:
  - Adds input port `Sub_in` (1 bit), captured at accept.
  - `Sub_in`=1: B words are inverted before `CLA_16` and the initial carry is forced to 1 (`C_in` ignored). Result is A−B; `C_out`=1 means no borrow.
  - `Sub_in`=0: plain add.
- Undefined: no `Sub_in` port, add only.

## Structure
- Shared package `mp_add_pkg`:
  - Word-width constant `MP_WORD_W`=16.
  - State typedef (IDLE/RUN/DONE).
  - `WORDS` legal-range constants.
- Exactly one sub-module: an instance of the existing `CLA_16`. Word selection, inversion, FSM and result registers live in `mp_add_seq`.

## Test plan
All scenarios use WORDS=4.
- **Reset:** assert `RST_in` mid-stream → `Ready_out`=1, `Valid_out`=0, `S_out`=0, `C_out`=0 while reset is held and after release.
- **Word-boundary carry:** A=0x0000_0000_0000_FFFF, B=0x1, `C_in`=0 → `S_out`=0x0000_0000_0001_0000, `C_out`=0. `Valid_out` rises 4 cycles after accept.
- **Full ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, `C_in`=1 → `S_out`=0, `C_out`=1.
- **Backpressure:**
  - Result A=0x7FF8+0x7FF8 → `S_out`=0xFFF0, `C_out`=0.
  - Hold `Ack_in`=0 for 5 cycles and pulse `Start_in` during them → `S_out`/`C_out`/`Valid_out` stay stable and the start is ignored.
  - Assert `Ack_in` → `Ready_out`=1 on the next cycle.
- **Reset mid-RUN:** accept, then assert `RST_in` 2 cycles later → IDLE with `S_out`=0. A following 1+1 request yields `S_out`=2.
- **`MPADD_SUB_EN`:** A=5, B=7, `Sub_in`=1 → `S_out`=0xFFFF_FFFF_FFFF_FFFE, `C_out`=0. A=7, B=5 → `S_out`=2, `C_out`=1.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared constants and types for the multi-precision add sequencer.
// One word per clock. The result is held until the requester acknowledges it.
package mp_add_pkg;

  localparam int MP_WORD_W  = 16;
  localparam int WORDS_MIN  = 1;
  localparam int WORDS_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_e;

endpackage

// File: rtl/mp_add_seq_if.sv
// Requester <-> sequencer bundle: start/ready request, operands, valid/ack result.
// Sub_in exists only when MPADD_SUB_EN is defined.
interface mp_add_seq_if
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
);

  logic                       Start_in;
  logic                       Ready_out;
  logic [MP_WORD_W*WORDS-1:0] A_in;
  logic [MP_WORD_W*WORDS-1:0] B_in;
  logic                       C_in;
`ifdef MPADD_SUB_EN
  logic                       Sub_in;
`endif
  logic                       Valid_out;
  logic                       Ack_in;
  logic [MP_WORD_W*WORDS-1:0] S_out;
  logic                       C_out;

  modport master (
    output Start_in, A_in, B_in, C_in, Ack_in,
`ifdef MPADD_SUB_EN
    output Sub_in,
`endif
    input  Ready_out, Valid_out, S_out, C_out
  );

  modport slave (
    input  Start_in, A_in, B_in, C_in, Ack_in,
`ifdef MPADD_SUB_EN
    input  Sub_in,
`endif
    output Ready_out, Valid_out, S_out, C_out
  );

endinterface

// File: rtl/mp_add_seq_cla16.sv
// 16-bit two-level carry-lookahead adder (4-bit groups) shared by the sequencer.
// Purely combinational; no backpressure.
module CLA_16 (
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        c_in,
  output logic [15:0] s_out,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = a_in & b_in;
  assign p = a_in ^ b_in;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      pg[i] = &p[4*i +: 4];
    end
  end

  // Group carries are flattened so no carry ripples across groups.
  assign cg[0] = c_in;
  assign cg[1] = gg[0] | (pg[0] & c_in);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & c_in);
  assign cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & c_in);

  always_comb begin
    logic cc;
    s_out = '0;
    cc    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cc = cg[i];
      for (int j = 0; j < 4; j++) begin
        s_out[4*i+j] = p[4*i+j] ^ cc;
        cc           = g[4*i+j] | (p[4*i+j] & cc);
      end
    end
  end

  assign c_out = cg[4];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: WORDS x 16-bit words through one CLA_16, LS word first; Valid WORDS cycles after accept.
// Result held in DONE until Ack; Start ignored outside IDLE. MPADD_SUB_EN adds Sub_in (A-B).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic         CLK_in,
  input  logic         RST_in,
  mp_add_seq_if.slave  bus
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef logic [WORDS-1:0][MP_WORD_W-1:0] words_t;

  mp_state_e      state_q, state_d;
  words_t         a_q, a_d;
  words_t         b_q, b_d;
  words_t         s_q, s_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [KW-1:0]  k_q, k_d;
  logic           sub_q, sub_d;

  logic [MP_WORD_W-1:0] cla_a, cla_b, cla_s;
  logic                 cla_co;

  assign cla_a = a_q[k_q];
  assign cla_b = sub_q ? ~b_q[k_q] : b_q[k_q];

  CLA_16 u_cla (
    .a_in  (cla_a),
    .b_in  (cla_b),
    .c_in  (carry_q),
    .s_out (cla_s),
    .c_out (cla_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (bus.Start_in) begin
          state_d = RUN;
          a_d     = bus.A_in;
          b_d     = bus.B_in;
          s_d     = '0;
          cout_d  = 1'b0;
          k_d     = '0;
`ifdef MPADD_SUB_EN
          sub_d   = bus.Sub_in;
          carry_d = bus.Sub_in | bus.C_in;
`else
          sub_d   = 1'b0;
          carry_d = bus.C_in;
`endif
        end
      end
      RUN: begin
        s_d[k_q] = cla_s;
        carry_d  = cla_co;
        if (k_q == KW'(WORDS - 1)) begin
          state_d = DONE;
          cout_d  = cla_co;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.Ack_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
      sub_q   <= sub_d;
    end
  end

  assign bus.Ready_out = (state_q == IDLE);
  assign bus.Valid_out = (state_q == DONE);
  assign bus.S_out     = s_q;
  assign bus.C_out     = cout_q;

endmodule
